lcd_text_ctrl: RTL and testbench

Parametrised HD44780-class character LCD controller and successor to the fixed 16x2 message writer.
- Holds a ROWS x COLS character frame buffer that the host writes one character at a time.
- Runs the LCD init sequence, then refreshes the panel whenever the buffer changes or a refresh is requested.
- Generates a proper enable strobe with setup and hold phases instead of gating the clock onto en.
- Sits between the traffic-light/mode logic and the LCD pins, on the slow LCD clock domain.

---
 rtl/lcd_pkg.sv | 17 +
 rtl/lcd_text_ctrl_if.sv | 19 +
 rtl/lcd_bus_xfer.sv | 39 +++
 rtl/lcd_text_ctrl.sv | 143 ++++++++++++++
 tb/tb_lcd_text_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: HD44780 command bytes, row base addresses and controller state type.
package lcd_pkg;
  localparam logic [7:0] CMD_FUNC_2L = 8'h38;
  localparam logic [7:0] CMD_FUNC_1L = 8'h30;
  localparam logic [7:0] CMD_DISP_ON = 8'h0C;
  localparam logic [7:0] CMD_ENTRY   = 8'h06;
  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_DDRAM   = 8'h80;
  typedef enum logic [1:0] {INIT, IDLE, SET_ADDR, WRITE_CHAR} state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  // Rows 2 and 3 of a 4-line panel continue rows 0 and 1 after COLS cells.
  function automatic logic [7:0] row_base(input int r, input int cols);
    return r == 0 ? 8'h00 : r == 1 ? 8'h40 : r == 2 ? 8'(cols) : 8'(64 + cols);
  endfunction
endpackage

// File: rtl/lcd_text_ctrl_if.sv
// lcd_text_ctrl_if: host character-write and status bus of the LCD text controller.
interface lcd_text_ctrl_if
  import lcd_pkg::*;
#(
  parameter int ROWS = 2,
  parameter int COLS = 16
);
  localparam int RW = idx_w(ROWS);
  localparam int CW = idx_w(COLS);
  logic          wr_en;
  logic [RW-1:0] wr_row;
  logic [CW-1:0] wr_col;
  logic [7:0]    wr_char;
  logic          refresh_req;
  logic          busy;
  logic          frame_done;
  modport master(output wr_en, wr_row, wr_col, wr_char, refresh_req, input busy, frame_done);
  modport slave(input wr_en, wr_row, wr_col, wr_char, refresh_req, output busy, frame_done);
endinterface

// File: rtl/lcd_bus_xfer.sv
// lcd_bus_xfer: one LCD byte as setup, EN_HIGH_CYC enable-high cycles and a hold cycle.
module lcd_bus_xfer #(
  parameter int EN_HIGH_CYC = 1
) (
  input  logic       clk_LCD,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] tx_byte,
  output logic       done,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);
  localparam int NW = $clog2(EN_HIGH_CYC + 2);
  logic          active;
  logic [NW-1:0] cnt;
  assign done = active && cnt == NW'(EN_HIGH_CYC + 1);
  // rs/data are captured once at launch so host writes cannot disturb a byte in flight.
  always_ff @(posedge clk_LCD) begin
    if (rst) begin
      active   <= 1'b0;
      cnt      <= '0;
      lcd_en   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
    end else if (start) begin
      active   <= 1'b1;
      cnt      <= '0;
      lcd_en   <= 1'b0;
      lcd_rs   <= rs;
      lcd_data <= tx_byte;
    end else if (active) begin
      active <= !done;
      cnt    <= cnt + 1'b1;
      lcd_en <= cnt < NW'(EN_HIGH_CYC);
    end
  end
endmodule

// File: rtl/lcd_text_ctrl.sv
// lcd_text_ctrl: character frame buffer with HD44780 init and full-panel redraw on change.
module lcd_text_ctrl
  import lcd_pkg::*;
#(
  parameter int COLS           = 16,
  parameter int ROWS           = 2,
  parameter int EN_HIGH_CYC    = 1,
  parameter int CLEAR_WAIT_CYC = 1
) (
  input  logic            clk_LCD,
  input  logic            rst,
  lcd_text_ctrl_if.slave  host,
  output logic            lcd_en,
  output logic            lcd_rs,
  output logic            lcd_rw,
  output logic [7:0]      lcd_data
);
  localparam int RW = idx_w(ROWS);
  localparam int CW = idx_w(COLS);
  localparam int WW = idx_w(CLEAR_WAIT_CYC + 1);
  localparam logic [7:0] FUNC_SET = ROWS > 1 ? CMD_FUNC_2L : CMD_FUNC_1L;
  state_t        state, state_n;
  logic [2:0]    ini, ini_n;
  logic [WW-1:0] wcnt, wcnt_n;
  logic [RW-1:0] row, row_n;
  logic [CW-1:0] col, col_n;
  logic          dirty, dirty_n, busy_q, fd_q, fd_n;
  logic          start, x_rs, done, wr_ok;
  logic [7:0]    x_byte;
  logic [7:0]    buf_q [ROWS][COLS];
  assign lcd_rw = 1'b0;
  assign host.busy = busy_q;
  assign host.frame_done = fd_q;
  assign wr_ok = host.wr_en && int'(host.wr_row) < ROWS && int'(host.wr_col) < COLS;
  lcd_bus_xfer #(.EN_HIGH_CYC(EN_HIGH_CYC)) u_xfer (
    .clk_LCD (clk_LCD),
    .rst     (rst),
    .start   (start),
    .rs      (x_rs),
    .tx_byte (x_byte),
    .done    (done),
    .lcd_en  (lcd_en),
    .lcd_rs  (lcd_rs),
    .lcd_data(lcd_data)
  );
  always_ff @(posedge clk_LCD) begin
    if (rst) begin
      state  <= INIT;
      ini    <= 3'd0;
      wcnt   <= '0;
      row    <= '0;
      col    <= '0;
      dirty  <= 1'b1;
      busy_q <= 1'b1;
      fd_q   <= 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          buf_q[r][c] <= 8'h20;
    end else begin
      state  <= state_n;
      ini    <= ini_n;
      wcnt   <= wcnt_n;
      row    <= row_n;
      col    <= col_n;
      dirty  <= dirty_n;
      busy_q <= !(state_n == IDLE && !dirty_n);
      fd_q   <= fd_n;
      if (wr_ok) buf_q[host.wr_row][host.wr_col] <= host.wr_char;
    end
  end
  // Each next byte is launched on the edge the previous one finishes, so transfers run back to back.
  always_comb begin
    state_n = state;
    ini_n   = ini;
    wcnt_n  = wcnt;
    row_n   = row;
    col_n   = col;
    fd_n    = 1'b0;
    start   = 1'b0;
    x_rs    = 1'b0;
    x_byte  = 8'h00;
    case (state)
      INIT: begin
        if (ini == 3'd0 || (ini < 3'd4 && done)) begin
          start  = 1'b1;
          x_byte = ini == 3'd0 ? FUNC_SET : ini == 3'd1 ? CMD_DISP_ON : ini == 3'd2 ? CMD_ENTRY : CMD_CLEAR;
          ini_n  = ini + 3'd1;
        end else if (ini == 3'd4 && done) begin
          if (CLEAR_WAIT_CYC == 0) state_n = IDLE;
          else begin
            ini_n  = 3'd5;
            wcnt_n = WW'(CLEAR_WAIT_CYC - 1);
          end
        end else if (ini == 3'd5) begin
          if (wcnt == '0) state_n = IDLE;
          else wcnt_n = wcnt - 1'b1;
        end
      end
      IDLE: begin
        if (dirty) begin
          start   = 1'b1;
          x_byte  = CMD_DDRAM | row_base(0, COLS);
          row_n   = '0;
          col_n   = '0;
          state_n = SET_ADDR;
        end
      end
      SET_ADDR: begin
        if (done) begin
          start   = 1'b1;
          x_rs    = 1'b1;
          x_byte  = buf_q[row][0];
          col_n   = '0;
          state_n = WRITE_CHAR;
        end
      end
      WRITE_CHAR: begin
        if (done && int'(col) == COLS - 1) begin
          col_n = '0;
          if (int'(row) == ROWS - 1) begin
            fd_n    = 1'b1;
            state_n = IDLE;
          end else begin
            start   = 1'b1;
            row_n   = row + 1'b1;
            x_byte  = CMD_DDRAM | row_base(int'(row) + 1, COLS);
            state_n = SET_ADDR;
          end
        end else if (done) begin
          start  = 1'b1;
          x_rs   = 1'b1;
          col_n  = col + 1'b1;
          x_byte = buf_q[row][col + 1'b1];
        end
      end
      default: begin
        state_n = INIT;
        ini_n   = 3'd0;
      end
    endcase
    dirty_n = wr_ok || host.refresh_req || (dirty && !(state == IDLE && dirty));
  end
endmodule

// File: tb/tb_lcd_text_ctrl.sv
// tb_lcd_text_ctrl: scoreboard bench for a 16x2 and a 20x4 (3-cycle enable) controller.
module tb_lcd_text_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst0 = 1'b1, rst1 = 1'b1;
  logic en0, rs0, rw0, en1, rs1, rw1;
  logic [7:0] d0, d1;
  lcd_text_ctrl_if #(.ROWS(2), .COLS(16)) h0();
  lcd_text_ctrl_if #(.ROWS(4), .COLS(20)) h1();
  lcd_text_ctrl #(.COLS(16), .ROWS(2), .EN_HIGH_CYC(1), .CLEAR_WAIT_CYC(1)) dut0 (
    .clk_LCD(clk), .rst(rst0), .host(h0), .lcd_en(en0), .lcd_rs(rs0), .lcd_rw(rw0), .lcd_data(d0));
  lcd_text_ctrl #(.COLS(20), .ROWS(4), .EN_HIGH_CYC(3), .CLEAR_WAIT_CYC(0)) dut1 (
    .clk_LCD(clk), .rst(rst1), .host(h1), .lcd_en(en1), .lcd_rs(rs1), .lcd_rw(rw1), .lcd_data(d1));
  int checks = 0, errors = 0, fd0 = 0, fd1 = 0;
  logic [8:0] q0[$], q1[$];
  logic [7:0] m0 [2][16];
  logic [7:0] m1 [4][20];
  logic pen0 = 1'b0, pen1 = 1'b0;
  int hi0 = 0, hi1 = 0;
  logic [8:0] cur0, cur1, psd0, psd1, exp0, exp1;
  // Monitors: every rising enable pops one expected {rs,data}; width and stability checked per byte.
  always @(negedge clk) begin
    if (rst0) pen0 = 1'b0;
    else begin
      if (en0 && !pen0) begin
        checks++;
        if (q0.size() == 0) begin errors++; $display("FAIL dut0 byte: got %h, expected none", {rs0, d0}); end
        else begin
          exp0 = q0.pop_front();
          if ({rs0, d0} !== exp0) begin errors++; $display("FAIL dut0 byte: got %h, expected %h", {rs0, d0}, exp0); end
        end
        checks++;
        if (psd0 !== {rs0, d0}) begin errors++; $display("FAIL dut0 setup: got %h, expected %h", psd0, {rs0, d0}); end
        cur0 = {rs0, d0};
        hi0 = 1;
      end else if (pen0) begin
        checks++;
        if ({rs0, d0} !== cur0) begin errors++; $display("FAIL dut0 stable: got %h, expected %h", {rs0, d0}, cur0); end
        if (en0) hi0++;
        else begin
          checks++;
          if (hi0 !== 1) begin errors++; $display("FAIL dut0 en_width: got %0d, expected 1", hi0); end
        end
      end
      pen0 = en0;
    end
    psd0 = {rs0, d0};
    if (h0.frame_done) fd0++;
  end
  always @(negedge clk) begin
    if (rst1) pen1 = 1'b0;
    else begin
      if (en1 && !pen1) begin
        checks++;
        if (q1.size() == 0) begin errors++; $display("FAIL dut1 byte: got %h, expected none", {rs1, d1}); end
        else begin
          exp1 = q1.pop_front();
          if ({rs1, d1} !== exp1) begin errors++; $display("FAIL dut1 byte: got %h, expected %h", {rs1, d1}, exp1); end
        end
        checks++;
        if (psd1 !== {rs1, d1}) begin errors++; $display("FAIL dut1 setup: got %h, expected %h", psd1, {rs1, d1}); end
        cur1 = {rs1, d1};
        hi1 = 1;
      end else if (pen1) begin
        checks++;
        if ({rs1, d1} !== cur1) begin errors++; $display("FAIL dut1 stable: got %h, expected %h", {rs1, d1}, cur1); end
        if (en1) hi1++;
        else begin
          checks++;
          if (hi1 !== 3) begin errors++; $display("FAIL dut1 en_width: got %0d, expected 3", hi1); end
        end
      end
      pen1 = en1;
    end
    psd1 = {rs1, d1};
    if (h1.frame_done) fd1++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push_init(input int u);
    logic [7:0] c [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
    for (int i = 0; i < 4; i++)
      if (u == 0) q0.push_back({1'b0, c[i]});
      else q1.push_back({1'b0, c[i]});
  endtask
  task automatic push_frame0();
    for (int r = 0; r < 2; r++) begin
      q0.push_back({1'b0, r == 0 ? 8'h80 : 8'hC0});
      for (int c = 0; c < 16; c++) q0.push_back({1'b1, m0[r][c]});
    end
  endtask
  task automatic push_frame1();
    logic [7:0] b [4] = '{8'h80, 8'hC0, 8'h94, 8'hD4};
    for (int r = 0; r < 4; r++) begin
      q1.push_back({1'b0, b[r]});
      for (int c = 0; c < 20; c++) q1.push_back({1'b1, m1[r][c]});
    end
  endtask
  task automatic wait_fd(input int u, input int lim, output int n);
    n = 0;
    do begin tick(); n++; end while (!(u == 0 ? h0.frame_done : h1.frame_done) && n < lim);
  endtask
  task automatic write0(input int r, input int c, input logic [7:0] ch);
    h0.wr_en = 1'b1; h0.wr_row = 1'(r); h0.wr_col = 4'(c); h0.wr_char = ch;
    tick();
    h0.wr_en = 1'b0;
  endtask
  task automatic write1(input int r, input int c, input logic [7:0] ch);
    h1.wr_en = 1'b1; h1.wr_row = 2'(r); h1.wr_col = 5'(c); h1.wr_char = ch;
    tick();
    h1.wr_en = 1'b0;
  endtask
  // Frame-done edge counted from release: launch edge + 4 init bytes + clear wait + IDLE + 34 bytes.
  task automatic test_reset();
    int n;
    rst0 = 1'b1;
    repeat (3) tick();
    checks++; if (en0 !== 1'b0) begin errors++; $display("FAIL reset_en: got %b, expected 0", en0); end
    checks++; if (rs0 !== 1'b0) begin errors++; $display("FAIL reset_rs: got %b, expected 0", rs0); end
    checks++; if (d0 !== 8'h00) begin errors++; $display("FAIL reset_data: got %h, expected 00", d0); end
    checks++; if (h0.busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b, expected 1", h0.busy); end
    checks++; if (h0.frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b, expected 0", h0.frame_done); end
    checks++; if (rw0 !== 1'b0) begin errors++; $display("FAIL reset_rw: got %b, expected 0", rw0); end
    foreach (m0[r, c]) m0[r][c] = 8'h20;
    push_init(0);
    push_frame0();
    rst0 = 1'b0;
    wait_fd(0, 300, n);
    checks++; if (n !== 1 + 4 * 3 + 1 + 1 + 34 * 3) begin errors++; $display("FAIL init_latency: got %0d, expected %0d", n, 117); end
    checks++; if (q0.size() !== 0) begin errors++; $display("FAIL init_bytes_left: got %0d, expected 0", q0.size()); end
    checks++; if (h0.busy !== 1'b0) begin errors++; $display("FAIL init_busy: got %b, expected 0", h0.busy); end
  endtask
  task automatic test_write();
    int n, f;
    write0(1, 5, 8'h41);
    m0[1][5] = 8'h41;
    push_frame0();
    wait_fd(0, 300, n);
    checks++; if (n !== 1 + 34 * 3) begin errors++; $display("FAIL write_latency: got %0d, expected %0d", n, 103); end
    checks++; if (q0.size() !== 0) begin errors++; $display("FAIL write_bytes_left: got %0d, expected 0", q0.size()); end
    tick();
    f = fd0;
    repeat (60) tick();
    checks++; if (fd0 !== f) begin errors++; $display("FAIL write_extra_frame: got %0d, expected %0d", fd0, f); end
    checks++; if (h0.busy !== 1'b0) begin errors++; $display("FAIL write_busy: got %b, expected 0", h0.busy); end
  endtask
  // Second write lands on the edge where IDLE clears dirty, so two redraws must follow.
  task automatic test_back_to_back();
    int f, n;
    f = fd0;
    write0(0, 3, 8'h42);
    write0(1, 0, 8'h43);
    m0[0][3] = 8'h42;
    m0[1][0] = 8'h43;
    push_frame0();
    push_frame0();
    n = 0;
    while (fd0 < f + 2 && n < 400) begin tick(); n++; end
    repeat (120) tick();
    checks++; if (fd0 !== f + 2) begin errors++; $display("FAIL b2b_frames: got %0d, expected %0d", fd0 - f, 2); end
    checks++; if (q0.size() !== 0) begin errors++; $display("FAIL b2b_bytes_left: got %0d, expected 0", q0.size()); end
  endtask
  task automatic test_mid_write();
    int f, n;
    f = fd0;
    h0.refresh_req = 1'b1;
    tick();
    h0.refresh_req = 1'b0;
    push_frame0();
    repeat (70) tick();
    write0(0, 0, 8'h58);
    m0[0][0] = 8'h58;
    push_frame0();
    n = 0;
    while (fd0 < f + 2 && n < 400) begin tick(); n++; end
    repeat (120) tick();
    checks++; if (fd0 !== f + 2) begin errors++; $display("FAIL mid_frames: got %0d, expected %0d", fd0 - f, 2); end
    checks++; if (q0.size() !== 0) begin errors++; $display("FAIL mid_bytes_left: got %0d, expected 0", q0.size()); end
    checks++; if (h0.busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b, expected 0", h0.busy); end
  endtask
  task automatic test_reset_mid();
    int n;
    h0.refresh_req = 1'b1;
    tick();
    h0.refresh_req = 1'b0;
    n = 0;
    while (!en0 && n < 20) begin tick(); n++; end
    checks++; if (en0 !== 1'b1) begin errors++; $display("FAIL rstmid_en_seen: got %b, expected 1", en0); end
    rst0 = 1'b1;
    tick();
    checks++; if (en0 !== 1'b0) begin errors++; $display("FAIL rstmid_en: got %b, expected 0", en0); end
    checks++; if (d0 !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h, expected 00", d0); end
    checks++; if (h0.busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy: got %b, expected 1", h0.busy); end
    q0.delete();
    foreach (m0[r, c]) m0[r][c] = 8'h20;
    push_init(0);
    push_frame0();
    tick();
    rst0 = 1'b0;
    wait_fd(0, 300, n);
    checks++; if (n !== 117) begin errors++; $display("FAIL rstmid_latency: got %0d, expected 117", n); end
    checks++; if (q0.size() !== 0) begin errors++; $display("FAIL rstmid_bytes_left: got %0d, expected 0", q0.size()); end
  endtask
  task automatic test_four_rows();
    int n, f;
    logic bad;
    foreach (m1[r, c]) m1[r][c] = 8'h20;
    push_init(1);
    push_frame1();
    rst1 = 1'b0;
    wait_fd(1, 600, n);
    checks++; if (n !== 1 + 4 * 5 + 0 + 1 + 84 * 5) begin errors++; $display("FAIL x4_init_latency: got %0d, expected 442", n); end
    checks++; if (q1.size() !== 0) begin errors++; $display("FAIL x4_init_bytes_left: got %0d, expected 0", q1.size()); end
    write1(3, 19, 8'h5A);
    m1[3][19] = 8'h5A;
    push_frame1();
    wait_fd(1, 600, n);
    checks++; if (n !== 1 + 84 * 5) begin errors++; $display("FAIL x4_write_latency: got %0d, expected 421", n); end
    checks++; if (q1.size() !== 0) begin errors++; $display("FAIL x4_write_bytes_left: got %0d, expected 0", q1.size()); end
    tick();
    f = fd1;
    write1(0, 20, 8'h21);
    write1(2, 31, 8'h22);
    bad = 1'b0;
    repeat (100) begin tick(); bad |= h1.busy; end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL x4_invalid_busy: got %b, expected 0", bad); end
    checks++; if (fd1 !== f) begin errors++; $display("FAIL x4_invalid_frames: got %0d, expected %0d", fd1, f); end
    h1.refresh_req = 1'b1;
    tick();
    h1.refresh_req = 1'b0;
    push_frame1();
    wait_fd(1, 600, n);
    checks++; if (q1.size() !== 0) begin errors++; $display("FAIL x4_refresh_bytes_left: got %0d, expected 0", q1.size()); end
  endtask
  initial begin
    h0.wr_en = 1'b0; h0.wr_row = '0; h0.wr_col = '0; h0.wr_char = 8'h00; h0.refresh_req = 1'b0;
    h1.wr_en = 1'b0; h1.wr_row = '0; h1.wr_col = '0; h1.wr_char = 8'h00; h1.refresh_req = 1'b0;
    test_reset();
    test_write();
    test_back_to_back();
    test_mid_write();
    test_reset_mid();
    test_four_rows();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
